// File: rtl/regfile_pkg.sv
// Shared register-file definitions: geometry of the 8x16 register file and
// the writeback entry carried by the writeback queue.
package regfile_pkg;
  localparam int REG_ADDR_WIDTH = 3;
  localparam int REG_DATA_WIDTH = 16;
  localparam int NUM_REGS       = 8;

  typedef struct packed {
    logic [REG_ADDR_WIDTH-1:0] addr;
    logic [REG_DATA_WIDTH-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/reg_writeback_queue_if.sv
// Writeback request handshake from execute/memory stages into the queue.
interface reg_writeback_queue_if
  import regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = REG_ADDR_WIDTH,
  parameter int DATA_WIDTH = REG_DATA_WIDTH
);
  logic                  wb_valid;
  logic                  wb_ready;
  logic [ADDR_WIDTH-1:0] wb_addr;
  logic [DATA_WIDTH-1:0] wb_data;

  modport master (output wb_valid, wb_addr, wb_data, input  wb_ready);
  modport slave  (input  wb_valid, wb_addr, wb_data, output wb_ready);
endinterface

// File: rtl/wbq_fwd_match.sv
// Youngest-match search over the pending queue entries for one operand address.
module wbq_fwd_match
  import regfile_pkg::*;
#(
  parameter  int DEPTH      = 4,
  parameter  int ADDR_WIDTH = REG_ADDR_WIDTH,
  parameter  int DATA_WIDTH = REG_DATA_WIDTH,
  localparam int PTR_W      = $clog2(DEPTH),
  localparam int CNT_W      = PTR_W + 1
)(
  input  logic [DEPTH-1:0][ADDR_WIDTH-1:0] addr_arr_i,
  input  logic [DEPTH-1:0][DATA_WIDTH-1:0] data_arr_i,
  input  logic [PTR_W-1:0]                 head_i,
  input  logic [CNT_W-1:0]                 pending_i,
  input  logic [ADDR_WIDTH-1:0]            addr_i,
  output logic                             hit_o,
  output logic [DATA_WIDTH-1:0]            data_o
);
  logic [PTR_W-1:0] idx;

  // Walk oldest to youngest; a later match overrides, so the youngest wins.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    idx    = head_i;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_i + PTR_W'(k);
      if ((CNT_W'(k) < pending_i) && (addr_arr_i[idx] == addr_i)) begin
        hit_o  = 1'b1;
        data_o = data_arr_i[idx];
      end
    end
  end
endmodule

// File: rtl/reg_writeback_queue.sv
// Writeback FIFO in front of the register file write port, with operand
// forwarding of pending values to read ports 1 and 2.
module reg_writeback_queue
  import regfile_pkg::*;
#(
  parameter  int DEPTH      = 4,
  parameter  int DATA_WIDTH = REG_DATA_WIDTH,
  parameter  int ADDR_WIDTH = REG_ADDR_WIDTH,
  localparam int PTR_W      = $clog2(DEPTH),
  localparam int CNT_W      = PTR_W + 1
)(
  input  logic                  CLK,
  input  logic                  Reset,
  reg_writeback_queue_if.slave  wb,
  input  logic                  rd3_req,
  input  logic [ADDR_WIDTH-1:0] rd3_addr,
  output logic [ADDR_WIDTH-1:0] Reg_address3,
  output logic [DATA_WIDTH-1:0] Reg_input_data,
  output logic                  Reg_Write,
  input  logic [ADDR_WIDTH-1:0] fwd_addr1,
  input  logic [ADDR_WIDTH-1:0] fwd_addr2,
  output logic                  fwd_hit1,
  output logic                  fwd_hit2,
  output logic [DATA_WIDTH-1:0] fwd_data1,
  output logic [DATA_WIDTH-1:0] fwd_data2,
  output logic [CNT_W-1:0]      pending,
  output logic                  empty
);
  logic [CNT_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [DEPTH-1:0][ADDR_WIDTH-1:0] addr_q;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] data_q;
  logic [PTR_W-1:0] hidx, tidx;
  logic full, push, pop;

  assign hidx    = head_q[PTR_W-1:0];
  assign tidx    = tail_q[PTR_W-1:0];
  assign pending = tail_q - head_q;
  assign empty   = (head_q == tail_q);
  // Full when the indices match but the wrap bits differ.
  assign full    = (head_q[PTR_W] != tail_q[PTR_W]) && (hidx == tidx);

  assign wb.wb_ready = !full;
  assign push        = wb.wb_valid && !full;
  assign pop         = !empty && !rd3_req;

  assign Reg_Write      = pop;
  assign Reg_address3   = rd3_req ? rd3_addr : addr_q[hidx];
  assign Reg_input_data = data_q[hidx];

  assign head_d = head_q + CNT_W'(pop);
  assign tail_d = tail_q + CNT_W'(push);

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      head_q <= '0;
      tail_q <= '0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      if (push) begin
        addr_q[tidx] <= wb.wb_addr;
        data_q[tidx] <= wb.wb_data;
      end
    end
  end

  logic [1:0][ADDR_WIDTH-1:0] fa;
  logic [1:0]                 fh;
  logic [1:0][DATA_WIDTH-1:0] fd;

  assign fa = {fwd_addr2, fwd_addr1};

  // Only stored entries are searched; an incoming request is never forwarded.
  for (genvar g = 0; g < 2; g++) begin : g_fwd
    wbq_fwd_match #(
      .DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)
    ) u_fwd (
      .addr_arr_i(addr_q),
      .data_arr_i(data_q),
      .head_i    (hidx),
      .pending_i (pending),
      .addr_i    (fa[g]),
      .hit_o     (fh[g]),
      .data_o    (fd[g])
    );
  end

  assign fwd_hit1  = fh[0];
  assign fwd_hit2  = fh[1];
  assign fwd_data1 = fd[0];
  assign fwd_data2 = fd[1];
endmodule

// File: tb/tb_reg_writeback_queue.sv
// Table-driven vectors plus a queue scoreboard for reg_writeback_queue.
module tb_reg_writeback_queue;
  import regfile_pkg::*;

  localparam int DEPTH = 4;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        rd3_req;
  logic [2:0]  rd3_addr, Reg_address3, fwd_addr1, fwd_addr2;
  logic [15:0] Reg_input_data, fwd_data1, fwd_data2;
  logic        Reg_Write, fwd_hit1, fwd_hit2, empty;
  logic [2:0]  pending;

  reg_writeback_queue_if wbi ();

  reg_writeback_queue #(.DEPTH(DEPTH)) dut (
    .CLK(CLK), .Reset(Reset), .wb(wbi.slave),
    .rd3_req(rd3_req), .rd3_addr(rd3_addr),
    .Reg_address3(Reg_address3), .Reg_input_data(Reg_input_data), .Reg_Write(Reg_Write),
    .fwd_addr1(fwd_addr1), .fwd_addr2(fwd_addr2),
    .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
    .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
    .pending(pending), .empty(empty)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic v; logic [2:0] a; logic [15:0] d; logic r; logic [2:0] ra;
    logic [2:0] f1; logic [2:0] f2;
    logic rdy; logic wr; logic ca; logic [2:0] a3; logic cd; logic [15:0] dd;
    logic h1; logic [15:0] d1; logic h2; logic [15:0] d2; logic [2:0] pend;
  } vec_t;

  vec_t      vecs [19];
  wb_entry_t sb [$];
  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_fwd(input logic [2:0] a, output logic h, output logic [15:0] d);
    h = 1'b0;
    d = '0;
    for (int i = sb.size() - 1; i >= 0; i--)
      if (!h && sb[i].addr == a) begin
        h = 1'b1;
        d = sb[i].data;
      end
  endtask

  task automatic apply(input vec_t v, input bit use_exp);
    wb_entry_t   e;
    logic        xh1, xh2, xrdy, xwr;
    logic [15:0] xd1, xd2;
    @(negedge CLK);
    wbi.wb_valid = v.v; wbi.wb_addr = v.a; wbi.wb_data = v.d;
    rd3_req = v.r; rd3_addr = v.ra; fwd_addr1 = v.f1; fwd_addr2 = v.f2;
    #1;
    xrdy = (sb.size() < DEPTH);
    xwr  = (sb.size() != 0) && !v.r;
    model_fwd(v.f1, xh1, xd1);
    model_fwd(v.f2, xh2, xd2);
    check("sb_wb_ready", wbi.wb_ready, xrdy);
    check("sb_reg_write", Reg_Write, xwr);
    check("sb_pending", pending, sb.size());
    check("sb_empty", empty, sb.size() == 0);
    check("sb_fwd_hit1", fwd_hit1, xh1);
    check("sb_fwd_data1", fwd_data1, xd1);
    check("sb_fwd_hit2", fwd_hit2, xh2);
    check("sb_fwd_data2", fwd_data2, xd2);
    if (v.r) check("sb_rd3_passthru", Reg_address3, v.ra);
    if (xwr && Reg_Write) begin
      e = sb.pop_front();
      check("sb_write_addr", Reg_address3, e.addr);
      check("sb_write_data", Reg_input_data, e.data);
    end else if (xwr) begin
      void'(sb.pop_front());
    end
    if (v.v && xrdy) sb.push_back('{addr: v.a, data: v.d});
    if (use_exp) begin
      check("vec_wb_ready", wbi.wb_ready, v.rdy);
      check("vec_reg_write", Reg_Write, v.wr);
      if (v.ca) check("vec_addr3", Reg_address3, v.a3);
      if (v.cd) check("vec_wdata", Reg_input_data, v.dd);
      check("vec_fwd_hit1", fwd_hit1, v.h1);
      check("vec_fwd_data1", fwd_data1, v.d1);
      check("vec_fwd_hit2", fwd_hit2, v.h2);
      check("vec_fwd_data2", fwd_data2, v.d2);
      check("vec_pending", pending, v.pend);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t idle;
    //           v a  d        r ra f1 f2 | rdy wr ca a3 cd dd       h1 d1       h2 d2     pend
    vecs[0]  = '{0,0,16'h0000,0,0, 0, 0,   1, 0, 1, 0, 1,16'h0000, 0,16'h0000, 0,16'h0000, 0};
    vecs[1]  = '{1,3,16'h1234,0,0, 3, 0,   1, 0, 1, 0, 1,16'h0000, 0,16'h0000, 0,16'h0000, 0};
    vecs[2]  = '{0,0,16'h0000,0,0, 3, 0,   1, 1, 1, 3, 1,16'h1234, 1,16'h1234, 0,16'h0000, 1};
    vecs[3]  = '{0,0,16'h0000,1,5, 0, 0,   1, 0, 1, 5, 0,16'h0000, 0,16'h0000, 0,16'h0000, 0};
    vecs[4]  = '{1,1,16'h0011,1,6, 0, 0,   1, 0, 1, 6, 0,16'h0000, 0,16'h0000, 0,16'h0000, 0};
    vecs[5]  = '{1,2,16'h0022,1,6, 1, 0,   1, 0, 1, 6, 0,16'h0000, 1,16'h0011, 0,16'h0000, 1};
    vecs[6]  = '{1,1,16'h0033,1,6, 1, 2,   1, 0, 1, 6, 0,16'h0000, 1,16'h0011, 1,16'h0022, 2};
    vecs[7]  = '{1,4,16'h0044,1,6, 1, 2,   1, 0, 1, 6, 0,16'h0000, 1,16'h0033, 1,16'h0022, 3};
    vecs[8]  = '{1,7,16'h0055,1,6, 4, 7,   0, 0, 1, 6, 0,16'h0000, 1,16'h0044, 0,16'h0000, 4};
    vecs[9]  = '{1,7,16'h0055,0,0, 1, 2,   0, 1, 1, 1, 1,16'h0011, 1,16'h0033, 1,16'h0022, 4};
    vecs[10] = '{1,7,16'h0055,0,0, 7, 3,   1, 1, 1, 2, 1,16'h0022, 0,16'h0000, 0,16'h0000, 3};
    vecs[11] = '{0,0,16'h0000,0,0, 7, 4,   1, 1, 1, 1, 1,16'h0033, 1,16'h0055, 1,16'h0044, 3};
    vecs[12] = '{0,0,16'h0000,0,0, 1, 0,   1, 1, 1, 4, 1,16'h0044, 0,16'h0000, 0,16'h0000, 2};
    vecs[13] = '{0,0,16'h0000,0,0, 0, 0,   1, 1, 1, 7, 1,16'h0055, 0,16'h0000, 0,16'h0000, 1};
    vecs[14] = '{0,0,16'h0000,0,0, 7, 0,   1, 0, 0, 0, 0,16'h0000, 0,16'h0000, 0,16'h0000, 0};
    vecs[15] = '{1,2,16'h0001,1,0, 2, 4,   1, 0, 1, 0, 0,16'h0000, 0,16'h0000, 0,16'h0000, 0};
    vecs[16] = '{1,5,16'h00AA,1,0, 2, 4,   1, 0, 1, 0, 0,16'h0000, 1,16'h0001, 0,16'h0000, 1};
    vecs[17] = '{1,2,16'h0BEE,1,0, 2, 4,   1, 0, 1, 0, 0,16'h0000, 1,16'h0001, 0,16'h0000, 2};
    vecs[18] = '{0,0,16'h0000,1,0, 2, 4,   1, 0, 1, 0, 0,16'h0000, 1,16'h0BEE, 0,16'h0000, 3};

    idle = vecs[0];

    Reset = 1'b1;
    wbi.wb_valid = 1'b0; wbi.wb_addr = '0; wbi.wb_data = '0;
    rd3_req = 1'b0; rd3_addr = '0; fwd_addr1 = '0; fwd_addr2 = '0;
    #3;
    check("rst_pending", pending, 0);
    check("rst_empty", empty, 1);
    check("rst_wb_ready", wbi.wb_ready, 1);
    check("rst_reg_write", Reg_Write, 0);
    check("rst_addr3", Reg_address3, 0);
    check("rst_wdata", Reg_input_data, 0);
    check("rst_fwd_hit1", fwd_hit1, 0);
    check("rst_fwd_hit2", fwd_hit2, 0);
    @(negedge CLK);
    Reset = 1'b0;

    foreach (vecs[i]) apply(vecs[i], 1'b1);

    // Reset lands mid-cycle with three entries pending.
    #1;
    Reset = 1'b1;
    #1;
    check("midrst_reg_write", Reg_Write, 0);
    check("midrst_pending", pending, 0);
    check("midrst_empty", empty, 1);
    check("midrst_fwd_hit1", fwd_hit1, 0);
    check("midrst_fwd_hit2", fwd_hit2, 0);
    sb.delete();
    @(negedge CLK);
    Reset = 1'b0;
    for (int i = 0; i < 3; i++) apply(idle, 1'b0);

    // Back-to-back enqueue/drain across several pointer wraps.
    for (int i = 0; i < 22; i++) begin
      vec_t s;
      s = idle;
      s.v = 1'b1; s.a = 3'(i % 8); s.d = 16'h0100 + 16'(i);
      s.f1 = 3'(i % 8); s.f2 = 3'((i + 7) % 8);
      apply(s, 1'b0);
      if (i > 0) check("stream_pending", pending, 1);
    end
    apply(idle, 1'b0);
    apply(idle, 1'b0);
    check("final_empty", empty, 1);
    check("final_sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
